apb_slave_mem: RTL and testbench

APB completer (slave) that answers the transfers driven by the team's APB bus functional model. It holds a word-addressed register memory and inserts a parameterised number of wait states per transfer. It flags out-of-range and misaligned accesses with `pslverr`. It is the DUT-side endpoint for the APB environment and serves as the reference responder in system benches.

---
 rtl/apb_slave_mem.sv | 127 ++++++++++++
 tb/tb_apb_slave_mem.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a word-addressed flop memory.
// Latency: setup + (1 + WAIT_CYCLES) access cycles; pready is a registered output.
// Backpressure: wait states are inserted through pready; a master abort ends the transfer without pready.
//
// Ports:
//   pclk, preset             clock and synchronous active-high reset
//   pselx, penable, pwrite   APB control from the requester
//   paddr, pwdata            byte address and write data
//   prdata, pready, pslverr  read data, transfer done, error response
module apb_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] BYTES_A = ADDR_WIDTH'(BYTES);
  // One extra bit so DEPTH itself is representable in the range compare.
  localparam logic [ADDR_WIDTH:0]   DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]            WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic                  r_err;
  logic                  r_pready;
  logic [IDXW-1:0]       r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_misalign;
  logic                  w_oor;
  logic                  w_err;
  logic [IDXW-1:0]       w_idx;
  logic                  w_setup;
  logic                  w_acc;

  assign w_word     = paddr / BYTES_A;
  assign w_misalign = (paddr % BYTES_A) != '0;
  assign w_oor      = {1'b0, w_word} >= DEPTH_A;
  assign w_err      = w_misalign || w_oor;
  // Truncation is safe: the index is only used to touch memory when w_oor is clear.
  assign w_idx      = w_word[IDXW-1:0];
  assign w_setup    = pselx && !penable;
  assign w_acc      = pselx && penable;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_pready <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pready <= 1'b0;
          // penable without a preceding setup phase is ignored here.
          if (w_setup) begin
            r_write <= pwrite;
            r_err   <= w_err;
            r_idx   <= w_idx;
            r_wdata <= pwdata;
            if (!pwrite) begin
              r_rdata <= w_err ? '0 : r_mem[w_idx];
            end
            r_cnt    <= WAIT_LD;
            // pready mirrors (ACCESS && cnt==0) one edge ahead so it is a flop.
            r_pready <= (WAIT_LD == 4'd0);
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!w_acc) begin
            // Master abort: drop the transfer, nothing is written.
            r_pready <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_cnt != 4'd0) begin
            r_cnt    <= r_cnt - 4'd1;
            r_pready <= (r_cnt == 4'd1);
          end else begin
            if (r_write && !r_err) begin
              r_mem[r_idx] <= r_wdata;
            end
            r_pready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_pready <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign prdata  = r_rdata;
  assign pready  = r_pready;
  assign pslverr = r_err && r_pready;

endmodule

// File: tb/tb_apb_slave_mem.sv
`timescale 1ns/1ps
module tb_apb_slave_mem;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int DEPTH = 64;

  logic          pclk = 1'b0;
  logic          preset;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  int            sel;

  logic          pselx0, pselx1;
  logic [DW-1:0] prdata0, prdata1, prdata_s;
  logic          pready0, pready1, pready_s;
  logic          pslverr0, pslverr1, pslverr_s;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory image per DUT: plain word arrays updated by rule.
  logic [DW-1:0] model [2][DEPTH];
  int            waits [2];

  assign pselx0    = psel && (sel == 0);
  assign pselx1    = psel && (sel == 1);
  assign prdata_s  = (sel == 0) ? prdata0  : prdata1;
  assign pready_s  = (sel == 0) ? pready0  : pready1;
  assign pslverr_s = (sel == 0) ? pslverr0 : pslverr1;

  always #5 pclk = ~pclk;

  apb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .preset(preset), .pselx(pselx0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
    .pclk(pclk), .preset(preset), .pselx(pselx1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        model[d][i] = '0;
  endtask

  // Idle cycles with the bus released; pready must stay low throughout.
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      psel = 1'b0;
      penable = 1'b0;
      @(posedge pclk);
      #1;
      check({tag, "_idle_pready"}, {31'd0, pready_s}, 32'd0);
      @(negedge pclk);
    end
  endtask

  // Full transfer, measured in cycles from setup to the pready cycle inclusive.
  task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic [DW-1:0] rd, output logic err, output int cyc);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    cyc = 1;
    @(negedge pclk);
    penable = 1'b1;
    cyc = 2;
    while (!pready_s && cyc < 40) begin
      @(negedge pclk);
      cyc++;
    end
    rd  = prdata_s;
    err = pslverr_s;
  endtask

  task automatic do_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    logic [DW-1:0] rd;
    logic          err;
    int            cyc;
    int            idx;
    bit            exp_err;
    idx     = int'(a) / 4;
    exp_err = (a[1:0] != 2'b00) || (idx >= DEPTH);
    xfer(wr, a, d, rd, err, cyc);
    check({tag, "_cycles"}, cyc, 2 + waits[sel]);
    check({tag, "_pslverr"}, {31'd0, err}, {31'd0, exp_err});
    if (!wr) check({tag, "_prdata"}, rd, exp_err ? 32'd0 : model[sel][idx]);
    if (wr && !exp_err) model[sel][idx] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            kind;

    waits[0] = 0;
    waits[1] = 3;
    sel = 0;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    preset = 1'b1;
    clear_model();
    repeat (3) @(posedge pclk);
    #1;
    check("rst_prdata0",  prdata0, 32'd0);
    check("rst_pready0",  {31'd0, pready0}, 32'd0);
    check("rst_pslverr0", {31'd0, pslverr0}, 32'd0);
    check("rst_prdata1",  prdata1, 32'd0);
    check("rst_pready1",  {31'd0, pready1}, 32'd0);
    check("rst_pslverr1", {31'd0, pslverr1}, 32'd0);
    @(negedge pclk);
    preset = 1'b0;

    // Error responses on both wait settings, then no corruption at 0x00.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_xfer(1'b1, 9'h100, 32'hCAFEF00D, "err_wr_oor");
      do_xfer(1'b0, 9'h002, 32'h0, "err_rd_misalign");
      do_xfer(1'b0, 9'h000, 32'h0, "err_rd_zero");
      idle(1, "err");
    end

    // Zero-wait write then read.
    sel = 0;
    do_xfer(1'b1, 9'h010, 32'hDEADBEEF, "zw_wr");
    do_xfer(1'b0, 9'h010, 32'h0, "zw_rd");
    idle(2, "zw");

    // Three wait states.
    sel = 1;
    do_xfer(1'b1, 9'h004, 32'h12345678, "ws_wr");
    do_xfer(1'b0, 9'h004, 32'h0, "ws_rd");
    idle(1, "ws");

    // Back-to-back on both DUTs.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_xfer(1'b1, 9'h000, 32'h11111111, "b2b_wr0");
      do_xfer(1'b1, 9'h004, 32'h22222222, "b2b_wr1");
      do_xfer(1'b1, 9'h008, 32'h33333333, "b2b_wr2");
      do_xfer(1'b0, 9'h000, 32'h0, "b2b_rd0");
      do_xfer(1'b0, 9'h004, 32'h0, "b2b_rd1");
      do_xfer(1'b0, 9'h008, 32'h0, "b2b_rd2");
      idle(1, "b2b");
    end

    // Reset in the middle of a write to 0x0C that already holds data.
    sel = 1;
    do_xfer(1'b1, 9'h00C, 32'h5A5A5A5A, "rst_pre_wr");
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h00C; pwdata = 32'hAAAA5555;
    @(negedge pclk);
    penable = 1'b1;
    preset = 1'b1;
    @(negedge pclk);
    check("rst_mid_pready", {31'd0, pready_s}, 32'd0);
    check("rst_mid_prdata", prdata_s, 32'd0);
    preset = 1'b0;
    clear_model();
    // Keep the bus in access phase a while: without a setup it must be ignored.
    repeat (5) begin
      @(negedge pclk);
      check("rst_mid_noacc", {31'd0, pready_s}, 32'd0);
    end
    idle(1, "rst_mid");
    do_xfer(1'b0, 9'h00C, 32'h0, "rst_mid_rd");
    sel = 0;
    do_xfer(1'b0, 9'h010, 32'h0, "rst_clr_rd0");
    idle(1, "rst_clr");

    // Master abort during wait states.
    sel = 1;
    do_xfer(1'b1, 9'h020, 32'h0BADC0DE, "abort_pre_wr");
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h020; pwdata = 32'hFFFF0000;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    check("abort_wait_pready", {31'd0, pready_s}, 32'd0);
    psel = 1'b0;
    penable = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      check("abort_after_pready", {31'd0, pready_s}, 32'd0);
    end
    do_xfer(1'b0, 9'h020, 32'h0, "abort_rd");
    idle(1, "abort");

    // Randomized traffic on both DUTs against the word-array model.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int t = 0; t < 60; t++) begin
        kind = $urandom_range(0, 5);
        case (kind)
          0, 1, 2: a = {1'b0, 6'($urandom_range(0, 63)), 2'b00};
          3:       a = {1'b0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
          default: a = {1'b1, 6'($urandom_range(0, 63)), 2'b00};
        endcase
        d = $urandom;
        do_xfer(1'($urandom_range(0, 1)), a, d, "rand");
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), "rand");
      end
      // Sweep a few words to compare the memory image.
      for (int i = 0; i < DEPTH; i += 7) begin
        a = 9'(i * 4);
        do_xfer(1'b0, a, 32'h0, "sweep_rd");
      end
      idle(1, "sweep");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
